// File: rtl/iob_regfile_2p_wr_arb_if.sv
// Requester-side and regfile-write-side bundle of the 2-port regfile write arbiter.
// Requesters drive the master modport; the arbiter sits on the slave modport.
interface iob_regfile_2p_wr_arb_if #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int WADDR_W = 8,
  parameter int LEN_W   = 4
);
  localparam int WSTRB_W = DATA_W / 8;

  logic [N_REQ-1:0]         req_valid_i;
  logic [N_REQ-1:0]         req_ready_o;
  logic [N_REQ*WADDR_W-1:0] req_addr_i;
  logic [N_REQ*LEN_W-1:0]   req_len_i;
  logic [N_REQ*DATA_W-1:0]  req_wdata_i;
  logic [N_REQ*WSTRB_W-1:0] req_wstrb_i;
  logic [N_REQ-1:0]         grant_o;
  logic                     busy_o;
  logic                     wen_o;
  logic [WADDR_W-1:0]       waddr_o;
  logic [WSTRB_W-1:0]       wstrb_o;
  logic [DATA_W-1:0]        wdata_o;

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_wdata_i, req_wstrb_i,
    input  req_ready_o, grant_o, busy_o, wen_o, waddr_o, wstrb_o, wdata_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_wdata_i, req_wstrb_i,
    output req_ready_o, grant_o, busy_o, wen_o, waddr_o, wstrb_o, wdata_o
  );
endinterface

// File: rtl/iob_regfile_2p_wr_arb.sv
// Round-robin arbiter sharing one regfile write port among N_REQ burst producers.
// A grant is locked for LEN+1 beats; write outputs are registered with an auto-incrementing address.
module iob_regfile_2p_wr_arb #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int WADDR_W = 8,
  parameter int LEN_W   = 4,
  localparam int WSTRB_W = DATA_W / 8
) (
  input  logic                        clk_i,
  input  logic                        cke_i,
  input  logic                        arst_n_i,
  iob_regfile_2p_wr_arb_if.slave      bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   prio_q, prio_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [WADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic               wen_q, wen_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic [WSTRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic               any_valid;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   idx;

  // Scan from the farthest offset down so the valid requester closest to prio is kept last.
  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((32'(prio_q) + k) % N_REQ);
      if (bus.req_valid_i[idx]) begin
        any_valid = 1'b1;
        pick      = idx;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    base_d   = base_q;
    remain_d = remain_q;
    beat_d   = beat_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d  = BURST;
          owner_d  = pick;
          grant_d  = N_REQ'(1) << pick;
          base_d   = bus.req_addr_i[pick*WADDR_W +: WADDR_W];
          remain_d = bus.req_len_i[pick*LEN_W +: LEN_W];
          beat_d   = '0;
        end
      end
      BURST: begin
        if (bus.req_valid_i[owner_q]) begin
          wen_d    = 1'b1;
          waddr_d  = base_q + WADDR_W'(beat_q) * WADDR_W'(WSTRB_W);
          wstrb_d  = bus.req_wstrb_i[owner_q*WSTRB_W +: WSTRB_W];
          wdata_d  = bus.req_wdata_i[owner_q*DATA_W +: DATA_W];
          beat_d   = beat_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == '0) begin
            state_d = IDLE;
            grant_d = '0;
            prio_d  = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      prio_q   <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      base_q   <= '0;
      remain_q <= '0;
      beat_q   <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
    end else if (cke_i) begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      base_q   <= base_d;
      remain_q <= remain_d;
      beat_q   <= beat_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
    end
  end

  // grant_q is zero outside BURST, so ready follows it directly even while cke_i is low.
  assign bus.req_ready_o = grant_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = (state_q == BURST);
  assign bus.wen_o       = wen_q;
  assign bus.waddr_o     = waddr_q;
  assign bus.wstrb_o     = wstrb_q;
  assign bus.wdata_o     = wdata_q;
endmodule

// File: tb/tb_iob_regfile_2p_wr_arb.sv
// Self-checking bench for iob_regfile_2p_wr_arb: directed scenarios plus random traffic,
// all compared against a transaction-level model of owner, priority and running address.
module tb_iob_regfile_2p_wr_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int LW = 4;
  localparam int SW = DW / 8;
  localparam int VW = N + 1 + 1 + AW + SW + DW + N;

  logic clk = 1'b0;
  logic cke;
  logic arst_n;
  always #5 clk = ~clk;

  iob_regfile_2p_wr_arb_if #(.N_REQ(N), .DATA_W(DW), .WADDR_W(AW), .LEN_W(LW)) bus ();

  iob_regfile_2p_wr_arb #(.N_REQ(N), .DATA_W(DW), .WADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i    (clk),
    .cke_i    (cke),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Model: owner index (-1 when nobody holds the port), priority, beats left, next address.
  int             m_owner;
  int             m_prio;
  int             m_remain;
  int             m_addr;
  logic           m_wen;
  logic [AW-1:0]  m_waddr;
  logic [SW-1:0]  m_wstrb;
  logic [DW-1:0]  m_wdata;

  task automatic model_reset();
    m_owner = -1; m_prio = 0; m_remain = 0; m_addr = 0;
    m_wen = 1'b0; m_waddr = '0; m_wstrb = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    if (!cke) return;
    m_wen = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_prio + k) % N;
        if (bus.req_valid_i[i]) begin
          m_owner  = i;
          m_addr   = int'(bus.req_addr_i[i*AW +: AW]);
          m_remain = int'(bus.req_len_i[i*LW +: LW]);
          break;
        end
      end
    end else if (bus.req_valid_i[m_owner]) begin
      m_wen   = 1'b1;
      m_waddr = AW'(m_addr);
      m_wstrb = bus.req_wstrb_i[m_owner*SW +: SW];
      m_wdata = bus.req_wdata_i[m_owner*DW +: DW];
      m_addr  = (m_addr + SW) % (1 << AW);
      if (m_remain == 0) begin
        m_prio  = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_remain--;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] g;
    g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    return {g, (m_owner >= 0), m_wen, m_waddr, m_wstrb, m_wdata, g};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.grant_o, bus.busy_o, bus.wen_o, bus.waddr_o, bus.wstrb_o, bus.wdata_o,
            bus.req_ready_o};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      bus.req_wdata_i[i*DW +: DW] = $urandom;
      bus.req_wstrb_i[i*SW +: SW] = SW'($urandom);
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    cke = 1'b1;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_len_i   = '0;
    rand_data();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (dut_vec() !== '0) begin
      tests_failed++;
      $display("FAIL reset_values got=%h exp=0", dut_vec());
    end
    // A one-beat burst from req1 moves the priority pointer off zero.
    bus.req_valid_i = 4'b0010;
    bus.req_len_i[1*LW +: LW] = '0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        bus.req_valid_i = 4'b1000;
        bus.req_addr_i[3*AW +: AW] = 8'h30;
        bus.req_len_i[3*LW +: LW] = 4'd5;
      end
      rand_data();
      step();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL reset_pre cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    arst_n = 1'b0;
    #2;
    tests_run++;
    if (dut_vec() !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_burst got=%h exp=0", dut_vec());
    end
    model_reset();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    bus.req_valid_i = 4'b1111;
    step();
    tests_run++;
    if (bus.grant_o !== 4'b0001 || bus.wen_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL grant_after_reset got grant=%b wen=%b exp grant=0001 wen=0",
               bus.grant_o, bus.wen_o);
    end
  endtask

  task automatic test_single_burst();
    logic [AW-1:0] aq[$];
    do_reset();
    bus.req_addr_i[1*AW +: AW] = 8'h10;
    bus.req_len_i[1*LW +: LW]  = 4'd3;
    bus.req_valid_i = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) bus.req_valid_i = '0;
      rand_data();
      step();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL single_burst cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (c == 0) begin
        tests_run++;
        if (bus.grant_o !== 4'b0010) begin
          tests_failed++;
          $display("FAIL single_grant got=%b exp=0010", bus.grant_o);
        end
      end
      if (bus.wen_o === 1'b1) aq.push_back(bus.waddr_o);
    end
    tests_run++;
    if (aq.size() != 4) begin
      tests_failed++;
      $display("FAIL single_beats got=%0d exp=4", aq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (aq[i] !== AW'(8'h10 + 4 * i)) begin
          tests_failed++;
          $display("FAIL single_addr beat=%0d got=%h exp=%h", i, aq[i], AW'(8'h10 + 4 * i));
        end
      end
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] eg;
    do_reset();
    bus.req_len_i   = '0;
    bus.req_valid_i = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      step();
      eg = (i % 2 == 0) ? (N'(1) << ((i / 2) % N)) : '0;
      tests_run++;
      if (bus.grant_o !== eg || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL rotation step=%0d grant got=%b exp=%b vec got=%h exp=%h",
                 i, bus.grant_o, eg, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_bubbles();
    logic [AW-1:0] aq[$];
    logic [7:0]    pat;
    pat = 8'b0011_0011;
    do_reset();
    bus.req_addr_i[2*AW +: AW] = 8'h40;
    bus.req_len_i[2*LW +: LW]  = 4'd2;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid_i = {1'b0, pat[i], 2'b00};
      rand_data();
      step();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL bubbles cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (i == 2 || i == 3) begin
        tests_run++;
        if (bus.grant_o !== 4'b0100 || bus.wen_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL bubble_hold step=%0d grant=%b wen=%b exp grant=0100 wen=0",
                   i, bus.grant_o, bus.wen_o);
        end
      end
      if (bus.wen_o === 1'b1) aq.push_back(bus.waddr_o);
    end
    tests_run++;
    if (aq.size() != 3 || aq[0] !== 8'h40 || aq[1] !== 8'h44 || aq[2] !== 8'h48) begin
      tests_failed++;
      $display("FAIL bubble_addrs got %0d beats exp 3 beats at 40,44,48", aq.size());
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] aq[$];
    do_reset();
    bus.req_addr_i[0 +: AW] = 8'hFC;
    bus.req_len_i[0 +: LW]  = 4'd1;
    bus.req_valid_i = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) bus.req_valid_i = '0;
      rand_data();
      step();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (bus.wen_o === 1'b1) aq.push_back(bus.waddr_o);
    end
    tests_run++;
    if (aq.size() != 2 || aq[0] !== 8'hFC || aq[1] !== 8'h00) begin
      tests_failed++;
      $display("FAIL wrap_addrs got %0d beats exp 2 beats at FC,00", aq.size());
    end
  endtask

  task automatic test_fairness();
    do_reset();
    bus.req_len_i[0 +: LW]    = 4'd2;
    bus.req_len_i[3*LW +: LW] = 4'd0;
    bus.req_valid_i = 4'b1001;
    for (int i = 0; i < 7; i++) begin
      if (i <= 4) begin
        tests_run++;
        if (bus.req_ready_o[3] !== 1'b0) begin
          tests_failed++;
          $display("FAIL fair_ready3 step=%0d got=%b exp=0", i, bus.req_ready_o[3]);
        end
      end
      rand_data();
      step();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL fairness cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (i == 4) begin
        tests_run++;
        if (bus.grant_o !== 4'b1000) begin
          tests_failed++;
          $display("FAIL fair_next got=%b exp=1000", bus.grant_o);
        end
      end
    end
  endtask

  task automatic test_cke();
    do_reset();
    bus.req_addr_i[1*AW +: AW] = 8'h80;
    bus.req_len_i[1*LW +: LW]  = 4'd3;
    bus.req_valid_i = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      cke = !(c >= 2 && c <= 4);
      rand_data();
      step();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL cke cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    cke = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.req_valid_i[i] = ($urandom_range(0, 9) < 7);
        bus.req_addr_i[i*AW +: AW] = AW'($urandom);
        bus.req_len_i[i*LW +: LW]  = ($urandom_range(0, 7) == 0) ? LW'($urandom) :
                                                                   LW'($urandom_range(0, 3));
      end
      cke = ($urandom_range(0, 9) != 0);
      rand_data();
      step();
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    cke = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    cke    = 1'b1;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_len_i   = '0;
    bus.req_wdata_i = '0;
    bus.req_wstrb_i = '0;
    model_reset();
    #12;
    test_reset();
    test_single_burst();
    test_rotation();
    test_bubbles();
    test_wrap();
    test_fairness();
    test_cke();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
